// File: rtl/attrib09_pack.sv
// Packs N_SYMS consecutive 2-bit symbols into one output word, first symbol in the LSBs.
// A flush closes a partial word (zero-padded) and reports how many symbols it holds.
module attrib09_pack #(
    parameter int N_SYMS = 4,
    parameter int LW     = $clog2(N_SYMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            inp,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [2*N_SYMS-1:0]   out,
    output logic [LW-1:0]         out_len,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [LW-1:0]         cnt_q, cnt_d;
    logic [2*N_SYMS-1:0]   acc_q, acc_d;
    logic [2*N_SYMS-1:0]   out_q, out_d;
    logic [LW-1:0]         out_len_q, out_len_d;
    logic                  out_valid_q, out_valid_d;

    logic                  acc_en;
    logic                  take;
    logic                  last;
    logic                  emit;
    logic [2*N_SYMS-1:0]   word;
    logic [LW-1:0]         word_len;

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        acc_en   = in_ready && (in_valid || flush);
        take     = acc_en && in_valid;
        last     = (cnt_q == LW'(N_SYMS - 1));
        word_len = cnt_q + LW'(take);

        // One-hot position decode of the fill counter; exactly one slot matches.
        word = acc_q;
        for (int k = 0; k < N_SYMS; k++) begin
            if (take && (cnt_q == LW'(k))) begin
                word[2*k +: 2] = inp;
            end
        end

        // A flush that lands on the last symbol is just the complete case.
        emit = (take && last) || (acc_en && flush && (take || (cnt_q != '0)));

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q && !out_ready;

        if (emit) begin
            out_d       = word;
            out_len_d   = word_len;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            acc_d       = '0;
        end else if (take) begin
            acc_d = word;
            cnt_d = cnt_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_attrib09_pack.sv
// Scoreboard bench for attrib09_pack: a symbol-list model predicts every emitted word
// and the ready/valid behaviour cycle by cycle.
module tb_attrib09_pack;

    localparam int N  = 4;
    localparam int LW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      inp;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [2*N-1:0]  out;
    logic [LW-1:0]   out_len;
    logic            out_valid;
    logic            out_ready;

    attrib09_pack #(.N_SYMS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*N-1:0] w;
        logic [LW-1:0]  len;
    } word_t;

    int         n_chk = 0;
    int         n_err = 0;
    logic [1:0] syms[$];
    word_t      exp_q[$];
    logic       m_ov;
    word_t      last_pop;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, req, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; inp = 2'd0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_ovld", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_len", {29'd0, out_len}, 32'd0);
        chk("rst_irdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        syms.delete(); exp_q.delete(); m_ov = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, advance model, clock.
    task automatic step(input logic [1:0] s, input logic v, input logic f, input logic r);
        logic  m_rdy;
        word_t nw;
        inp = s; in_valid = v; flush = f; out_ready = r;
        #1;
        m_rdy = !m_ov || r;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("out", {24'd0, out}, {24'd0, exp_q[0].w});
                chk("out_len", {29'd0, out_len}, {29'd0, exp_q[0].len});
                if (r) begin
                    last_pop = exp_q.pop_front();
                    m_ov = 1'b0;
                end
            end
        end
        if (m_rdy && v) syms.push_back(s);
        if (m_rdy && (v || f) && ((syms.size() == N) || (f && syms.size() > 0))) begin
            nw.w = '0;
            foreach (syms[i]) nw.w[2*i +: 2] = syms[i];
            nw.len = LW'(syms.size());
            exp_q.push_back(nw);
            syms.delete();
            m_ov = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        m_ov = 1'b0;
        last_pop = '0;
        do_reset();

        // Full word 3,2,1,0
        step(2'd3, 1, 0, 1); step(2'd2, 1, 0, 1); step(2'd1, 1, 0, 1); step(2'd0, 1, 0, 1);
        step(2'd0, 0, 0, 1);
        chk("full_word", {24'd0, last_pop.w}, 32'h1B);
        chk("full_len", {29'd0, last_pop.len}, 32'd4);

        // Empty flush straight after a completed word
        step(2'd0, 0, 1, 1);
        step(2'd0, 0, 0, 1);

        // Backpressure: 8 offers of 2 with out_ready low, then drain
        for (int i = 0; i < 8; i++) step(2'd2, 1, 0, 0);
        step(2'd2, 0, 0, 1);
        chk("bp_word", {24'd0, last_pop.w}, 32'hAA);
        step(2'd1, 1, 0, 1);

        // Partial flush: 1, then 3 with flush (after the pending symbol above)
        step(2'd0, 0, 1, 1);
        step(2'd0, 0, 0, 1);
        step(2'd1, 1, 0, 1); step(2'd3, 1, 1, 1);
        step(2'd0, 0, 0, 1);
        chk("flush_word", {24'd0, last_pop.w}, 32'h0D);
        chk("flush_len", {29'd0, last_pop.len}, 32'd2);

        // Back-to-back: 12 symbols continuous
        for (int i = 0; i < 12; i++) step(2'(i), 1, 0, 1);
        step(2'd0, 0, 0, 1);

        // Reset mid-word, then 0,0,0,1
        step(2'd3, 1, 0, 1); step(2'd3, 1, 0, 1); step(2'd3, 1, 0, 1);
        do_reset();
        step(2'd0, 1, 0, 1); step(2'd0, 1, 0, 1); step(2'd0, 1, 0, 1); step(2'd1, 1, 0, 1);
        step(2'd0, 0, 0, 1);
        chk("rst_mid_word", {24'd0, last_pop.w}, 32'h40);
        chk("rst_mid_len", {29'd0, last_pop.len}, 32'd4);

        // Random mix of valid, flush and backpressure
        for (int i = 0; i < 200; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));
        end
        step(2'd0, 0, 1, 1);
        step(2'd0, 0, 0, 1);
        step(2'd0, 0, 0, 1);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/attrib09_pack.md
# attrib09_pack

Downstream stage of the 2-bit code inverter in the attribute-test designs: it consumes the 2-bit symbol stream produced by that inverter and packs `N_SYMS` consecutive symbols into one output word. Transfers on both sides use valid/ready handshakes. A `flush` input emits a partially filled word, zero-padded, together with its symbol count. The block exercises `full_case`/`parallel_case` decoding of its fill counter alongside real sequential state.

## Interface
- `N_SYMS`, default 4: symbols per output word; must be ≥2.
- `LW`, derived as `$clog2(N_SYMS+1)`, default 3: width of `out_len`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `inp` input 2: input symbol, normally the inverter's `out`.
- `in_valid` input 1: `inp` and `flush` are valid.
- `in_ready` output 1: block can accept this cycle; combinational.
- `flush` input 1: qualified by the input handshake; closes the current word.
- `out` output 2*N_SYMS: packed word.
- `out_len` output LW: number of valid symbols in `out`, from 1 to N_SYMS.
- `out_valid` output 1: `out` and `out_len` are valid.
- `out_ready` input 1: downstream accepts this cycle.

## Operation
- **State**
  - `cnt`: symbols held, 0..N_SYMS-1.
  - `acc[2*N_SYMS-1:0]`: accumulator.
  - Output register: `out`, `out_len`, `out_valid`.
- **Ready:** `in_ready = !out_valid || out_ready`.
- **Accept:** `acc_en = in_ready && (in_valid || flush)`. A flush with `in_valid` low is legal.
- **Packing:** the k-th accepted symbol of a word (k = 0 first) occupies bits [2k+1:2k]. The first symbol lands in the LSBs.
- **Complete:** an accepted symbol with `cnt == N_SYMS-1`:
  - Output register loads `{inp, acc[2*N_SYMS-3:0]}` with `out_len = N_SYMS`.
  - `out_valid` is set; `cnt` and `acc` clear to 0.
- **Flush:** `flush` with `acc_en` and `cnt + (in_valid ? 1 : 0) > 0`:
  - The word is emitted as it stands, including `inp` when `in_valid` is high.
  - Unfilled positions are 0; `out_len` = symbols included; `cnt` and `acc` clear.
- **Empty flush:** `flush` with `cnt == 0` and `in_valid` low is a no-op; `out_valid` is not set.
- **Flush on the last symbol:** coincides with the complete case; only one word is emitted, with `out_len = N_SYMS`.
- **Otherwise:** an accepted symbol is written at position `cnt`, and `cnt` increments.
- **Output drain:** `out_valid && out_ready` with no new word clears `out_valid`. `out` and `out_len` hold their last values.
- **Simultaneous drain and new word:** the output register reloads and `out_valid` stays 1. There is no bubble.
- **Stall:** while `out_valid && !out_ready`, `out` and `out_len` are stable and `in_ready` = 0. `cnt` and `acc` do not change.
- **Counter decode:** the position decode on `cnt` is a full, parallel case over 0..N_SYMS-1.
- **Reset:**
  - `out_valid` = 0, `out` = 0, `out_len` = 0, `cnt` = 0, `acc` = 0.
  - `in_ready` is 1 during and after reset.
  - Reset mid-word discards partial symbols and any pending output word.

## Timing
- Latency: one cycle from the accepting edge of the completing or flushing symbol to `out_valid` high.
- Throughput: with `out_ready` held at 1, one symbol per cycle sustained and one word every N_SYMS cycles.
- `in_ready` depends combinationally on `out_ready`. There is no other input-to-output combinational path.
- `rst` has priority over every handshake in the same cycle.

## Test plan
- **Full word:** after reset, `in_valid` = 1 with `inp` = 3, 2, 1, 0 on consecutive cycles and `out_ready` = 1. Required: `out_valid` pulses one cycle after the 4th accept, with `out` = 8'h1B and `out_len` = 4. `in_ready` stays 1 throughout.
- **Backpressure:** `out_ready` = 0 while offering 8 symbols, all `inp` = 2.
  - Only 4 are accepted; `out` = 8'hAA, and `in_ready` = 0 from the next cycle.
  - Raising `out_ready` drains that word in one cycle and resumes acceptance.
- **Partial flush:** accept `inp` = 1, then `inp` = 3 with `flush` = 1. Required: `out` = 8'h0D and `out_len` = 2 the next cycle. The next word starts at position 0.
- **Empty flush:** right after a word completes, assert `flush` with `in_valid` = 0. Required: `out_valid` does not rise; `cnt` stays 0.
- **Back-to-back:** 12 symbols continuous with `out_ready` = 1. Required: 3 words with no `in_ready` deassertion, and `out_valid` high on the 5th, 9th and 13th cycles after the first accept.
- **Reset mid-word:** accept 3 symbols, pulse `rst` for one cycle, then send `inp` = 0, 0, 0, 1. Required: `out` = 8'h40, `out_len` = 4; no earlier symbols leak into the word.
